instr_issue_seq: RTL and testbench

Fetch-side issue sequencer feeding the control unit. Accepts 32-bit RV32I instructions over a valid/ready handshake and classifies the opcode into the 3-bit `type_select` code (`opcode[6:4]`). Extracts register fields and the sign-extended immediate, then sequences single-cycle (R, R_imm, B) and two-phase (Load, Store) execution. Flags illegal opcodes and counts retired instructions.

---
 rtl/instr_issue_seq_pkg.sv | 43 ++++
 rtl/instr_issue_seq_if.sv | 18 +
 rtl/instr_issue_seq_imm_gen.sv | 33 +++
 rtl/instr_issue_seq.sv | 153 +++++++++++++++
 tb/tb_instr_issue_seq.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_issue_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_issue_seq_pkg
// Definitions shared by the issue sequencer and the control unit:
//   - type_t     : 3-bit type_select codes (opcode[6:4])
//   - state_t    : sequencer FSM state encoding
//   - OPCODE_LOW : opcode[1:0] value of every 32-bit RV32I instruction
//   - is_legal() / is_mem_type() : decode helpers
// -----------------------------------------------------------------------------
package instr_issue_seq_pkg;

  typedef enum logic [2:0] {
    TYPE_LOAD  = 3'b000,
    TYPE_R_IMM = 3'b001,
    TYPE_STORE = 3'b010,
    TYPE_R     = 3'b011,
    TYPE_B     = 3'b110
  } type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MEM  = 2'b10,
    ST_TRAP = 2'b11
  } state_t;

  localparam logic [1:0] OPCODE_LOW = 2'b11;

  // Only the five supported major opcodes are legal; opcode[3:2] must be 00.
  function automatic logic is_legal(input logic [6:0] opcode);
    logic type_ok;
    case (opcode[6:4])
      TYPE_LOAD, TYPE_R_IMM, TYPE_STORE, TYPE_R, TYPE_B: type_ok = 1'b1;
      default:                                           type_ok = 1'b0;
    endcase
    return type_ok && (opcode[1:0] == OPCODE_LOW) && (opcode[3:2] == 2'b00);
  endfunction

  // Load and Store need a second (MEM) phase before they retire.
  function automatic logic is_mem_type(input logic [2:0] type_code);
    return (type_code == TYPE_LOAD) || (type_code == TYPE_STORE);
  endfunction

endpackage

// File: rtl/instr_issue_seq_if.sv
// -----------------------------------------------------------------------------
// instr_issue_seq_if
// Fetch -> sequencer instruction handshake.
//   instr_valid : upstream presents an instruction on instr
//   instr_ready : sequencer can accept (transfer when both are high)
//   instr       : raw instruction word
// Modports: master = fetch side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface instr_issue_seq_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/instr_issue_seq_imm_gen.sv
// -----------------------------------------------------------------------------
// instr_issue_seq_imm_gen
// Combinational sign-extended immediate generator.
//   instr       in  [31:7] instruction bits above the opcode
//   type_select in  3      type code (opcode[6:4]) of the same instruction
//   imm         out XLEN   immediate; 0 for R-type and unsupported codes
// -----------------------------------------------------------------------------
module instr_issue_seq_imm_gen
  import instr_issue_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      type_select,
  output logic [XLEN-1:0] imm
);

  logic sign;
  assign sign = instr[31];

  always_comb begin
    // NOTE: default first so every path assigns imm and no latch is inferred.
    imm = '0;
    case (type_select)
      TYPE_LOAD, TYPE_R_IMM: imm = {{(XLEN-12){sign}}, instr[31:20]};
      TYPE_STORE:            imm = {{(XLEN-12){sign}}, instr[31:25], instr[11:7]};
      TYPE_B:                imm = {{(XLEN-13){sign}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
      default:               imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_issue_seq.sv
// -----------------------------------------------------------------------------
// instr_issue_seq
// Fetch-side issue sequencer. Accepts one instruction in IDLE, registers its
// decoded fields, then runs a one-cycle EXEC phase (R, R_imm, B) or EXEC+MEM
// (Load, Store, MEM waits for mem_done). Illegal opcodes park in TRAP until
// trap_clr. Each legal instruction pulses retire once and bumps retired_cnt.
//   clk, rst          clock, asynchronous active-high reset
//   bus (slave)       instr_valid / instr_ready / instr handshake
//   type_select       registered opcode[6:4]
//   exec_valid        fields are live (EXEC, MEM)
//   rd, rs1, rs2      registered register fields
//   funct3, funct7    registered function fields
//   imm               registered sign-extended immediate
//   mem_done          data memory finished (only looked at in MEM)
//   retire            one-cycle pulse in the last cycle of a legal instruction
//   retired_cnt       wrapping count of retire pulses
//   illegal           high while in TRAP
//   trap_clr          leave TRAP (only looked at in TRAP)
// -----------------------------------------------------------------------------
module instr_issue_seq
  import instr_issue_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  instr_issue_seq_if.slave    bus,
  output logic [2:0]          type_select,
  output logic                exec_valid,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [XLEN-1:0]     imm,
  input  logic                mem_done,
  output logic                retire,
  output logic [XLEN-1:0]     retired_cnt,
  output logic                illegal,
  input  logic                trap_clr
);

  state_t          state_q, state_d;
  logic            ready;
  logic            accept;
  logic [XLEN-1:0] imm_next;
  logic [XLEN-1:0] cnt_q;

  logic [2:0]      type_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [XLEN-1:0] imm_q;

  assign accept = bus.instr_valid && ready;

  // The immediate is formed from the incoming word's own opcode, so it is
  // ready to be captured together with the other fields.
  instr_issue_seq_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr       (bus.instr[31:7]),
    .type_select (bus.instr[6:4]),
    .imm         (imm_next)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignment for every flop so all state updates
      // see the same pre-edge values, independent of block ordering.
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_legal(bus.instr[6:0]) ? ST_EXEC : ST_TRAP;
      ST_EXEC: state_d = is_mem_type(type_q) ? ST_MEM : ST_IDLE;
      ST_MEM:  if (mem_done) state_d = ST_IDLE;
      ST_TRAP: if (trap_clr) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // ready is masked by rst so the upstream never sees a transfer during reset.
  always_comb begin
    ready      = 1'b0;
    exec_valid = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_IDLE: ready = !rst;
      ST_EXEC: begin
        exec_valid = 1'b1;
        retire     = !is_mem_type(type_q);
      end
      ST_MEM: begin
        exec_valid = 1'b1;
        retire     = mem_done;
      end
      ST_TRAP: illegal = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign bus.instr_ready = ready;

  // ---------------- Captured fields ----------------
  // NOTE: the field registers are reset, not left free-running, because
  // downstream sees them and expects all-zero outputs during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q   <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm_q    <= '0;
    end else if (accept) begin
      type_q   <= bus.instr[6:4];
      rd_q     <= bus.instr[11:7];
      rs1_q    <= bus.instr[19:15];
      rs2_q    <= bus.instr[24:20];
      funct3_q <= bus.instr[14:12];
      funct7_q <= bus.instr[31:25];
      imm_q    <= imm_next;
    end
  end

  // ---------------- Retire counter (wraps silently) ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign type_select = type_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign funct3      = funct3_q;
  assign funct7      = funct7_q;
  assign imm         = imm_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_seq
// Self-checking bench for instr_issue_seq: directed cases for the documented
// instructions, then randomized instruction streams checked against a
// behavioural decode/retire model. Inputs change #1 after the rising edge;
// outputs are checked in the same window.
// -----------------------------------------------------------------------------
module tb_instr_issue_seq;

  logic        clk;
  logic        rst;
  logic [2:0]  type_select;
  logic        exec_valid;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        mem_done;
  logic        retire;
  logic [31:0] retired_cnt;
  logic        illegal;
  logic        trap_clr;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  instr_issue_seq_if #(.XLEN(32)) bus ();

  instr_issue_seq #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .type_select (type_select),
    .exec_valid  (exec_valid),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .mem_done    (mem_done),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .illegal     (illegal),
    .trap_clr    (trap_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decode of one instruction word, straight from the ISA rules.
  typedef struct {
    bit        legal;
    bit        two_phase;
    bit [2:0]  typ;
    bit [4:0]  rd, rs1, rs2;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [31:0] imm;
  } exp_t;

  function automatic exp_t model_decode(input logic [31:0] w);
    exp_t e;
    int   v;
    e.typ = w[6:4];
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.f3  = w[14:12];
    e.f7  = w[31:25];
    e.legal = (w[1:0] == 2'b11) && (w[3:2] == 2'b00) &&
              (e.typ inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110});
    e.two_phase = (e.typ == 3'b000) || (e.typ == 3'b010);
    case (e.typ)
      3'b000, 3'b001: v = int'($signed(w[31:20]));
      3'b010:         v = int'($signed({w[31:25], w[11:7]}));
      3'b110:         v = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      default:        v = 0;
    endcase
    e.imm = v;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input exp_t e);
    check("type_select", type_select, e.typ);
    check("rd", rd, e.rd);
    check("rs1", rs1, e.rs1);
    check("rs2", rs2, e.rs2);
    check("funct3", funct3, e.f3);
    check("funct7", funct7, e.f7);
    if (e.legal) check("imm", imm, e.imm);
  endtask

  // Issue one word and walk it to completion. lat = mem_done-low cycles in MEM.
  task automatic issue(input logic [31:0] w, input int lat);
    exp_t e;
    e = model_decode(w);
    check("ready_idle", bus.instr_ready, 1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom();   // must not disturb captured fields
    check_fields(e);
    check("ready_busy", bus.instr_ready, 0);
    if (!e.legal) begin
      check("trap_illegal", illegal, 1);
      check("trap_exec_valid", exec_valid, 0);
      check("trap_retire", retire, 0);
      repeat ($urandom_range(0, 3)) begin
        mem_done        = 1'($urandom());
        bus.instr_valid = 1'b1;
        #1;
        check("trap_hold_retire", retire, 0);
        step();
        check("trap_hold_illegal", illegal, 1);
        check("trap_hold_ready", bus.instr_ready, 0);
      end
      bus.instr_valid = 1'b0;
      mem_done        = 1'b0;
      trap_clr        = 1'b1;
      step();
      trap_clr = 1'b0;
      check("trap_exit_ready", bus.instr_ready, 1);
      check("trap_exit_illegal", illegal, 0);
      check("trap_cnt", retired_cnt, exp_cnt);
    end else if (!e.two_phase) begin
      check("exec_valid", exec_valid, 1);
      check("retire_single", retire, 1);
      check("illegal_low", illegal, 0);
      mem_done = 1'($urandom());
      step();
      mem_done = 1'b0;
      exp_cnt  = exp_cnt + 1;
      check("cnt_single", retired_cnt, exp_cnt);
      check("retire_drop", retire, 0);
      check("ready_back", bus.instr_ready, 1);
      check("exec_valid_drop", exec_valid, 0);
    end else begin
      check("exec_valid_mem", exec_valid, 1);
      mem_done = 1'b1;                 // ignored in EXEC
      #1;
      check("exec_no_retire", retire, 0);
      step();
      mem_done = 1'b0;
      for (int i = 0; i < lat; i++) begin
        #1;
        check("mem_wait_retire", retire, 0);
        check("mem_wait_valid", exec_valid, 1);
        check_fields(e);
        step();
      end
      mem_done = 1'b1;
      #1;
      check("mem_retire", retire, 1);
      check("mem_ready", bus.instr_ready, 0);
      check_fields(e);
      step();
      mem_done = 1'b0;
      exp_cnt  = exp_cnt + 1;
      check("cnt_mem", retired_cnt, exp_cnt);
      check("ready_after_mem", bus.instr_ready, 1);
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin
      bus.instr = $urandom();
      mem_done  = 1'($urandom());
      trap_clr  = 1'($urandom());
      #1;
      check("gap_retire", retire, 0);
      check("gap_ready", bus.instr_ready, 1);
      step();
      check("gap_cnt", retired_cnt, exp_cnt);
    end
    mem_done = 1'b0;
    trap_clr = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  t;
    w = $urandom();
    if ($urandom_range(0, 9) < 8) begin
      case ($urandom_range(0, 4))
        0:       t = 3'b000;
        1:       t = 3'b001;
        2:       t = 3'b010;
        3:       t = 3'b011;
        default: t = 3'b110;
      endcase
      w[6:0] = {t, 4'b0011};
    end
    return w;
  endfunction

  initial begin
    checks          = 0;
    errors          = 0;
    exp_cnt         = '0;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    mem_done        = 1'b0;
    trap_clr        = 1'b0;

    // Reset state
    #2;
    check("rst_ready", bus.instr_ready, 0);
    check("rst_exec_valid", exec_valid, 0);
    check("rst_type", type_select, 0);
    check("rst_imm", imm, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retire", retire, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus.instr_ready, 1);

    // Directed: add x3,x1,x2 ; lw x1,-4(x2) with 3 wait cycles ; beq -4
    issue(32'h0020_81B3, 0);
    check("add_cnt", retired_cnt, 1);
    issue(32'hFFC1_2083, 3);
    issue(32'hFE00_0EE3, 0);
    check("beq_imm", imm, 32'hFFFF_FFFC);
    // Illegal then a normal R-type
    issue(32'h0000_007F, 0);
    issue(32'h0020_81B3, 0);
    check("after_trap_cnt", retired_cnt, 4);

    // Randomized stream
    for (int n = 0; n < 60; n++) begin
      issue(rand_instr(), $urandom_range(0, 4));
      idle_gap();
    end

    // Reset in the middle of MEM for sw x1,8(x2)
    bus.instr       = 32'h0011_2423;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    check("sw_imm", imm, 32'h0000_0008);
    step();
    check("sw_in_mem", exec_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_exec_valid", exec_valid, 0);
    check("midrst_type", type_select, 0);
    check("midrst_rd", rd, 0);
    check("midrst_imm", imm, 0);
    check("midrst_cnt", retired_cnt, 0);
    check("midrst_retire", retire, 0);
    check("midrst_ready", bus.instr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    check("midrst_release_ready", bus.instr_ready, 1);
    step();
    check("midrst_idle_cnt", retired_cnt, 0);

    // Counter wrap from all-ones
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("preload_cnt", retired_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    issue(32'h0020_81B3, 0);
    check("wrap_cnt", retired_cnt, 0);
    issue(32'hFFC1_2083, 1);
    check("post_wrap_cnt", retired_cnt, 1);

    for (int n = 0; n < 10; n++) begin
      issue(rand_instr(), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
